sram_like_responder: RTL and testbench

- Target-side model of the SRAM-like bus the CPU core drives on its inst_* / data_* ports (req/wr/wstrb/addr/size/wdata out; addr_ok/data_ok/rdata in).
- Backs one bus with a local word RAM. Accepts requests in order, returns exactly one data_ok per accepted request after a programmable latency, and can inject pseudo-random addr_ok stalls.
- Used as inst-side and data-side memory in core-level simulation and FPGA bring-up.

---
 rtl/sram_like_responder_pkg.sv | 28 ++
 rtl/sram_like_responder_resp_fifo.sv | 70 +++++++
 rtl/sram_like_responder.sv | 91 +++++++++
 tb/tb_sram_like_responder.sv | 421 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_like_responder_pkg.sv
// Shared definitions for the SRAM-like bus that the core drives on its inst_* and data_* ports.
// Holds the field widths, the transfer-size encodings and a byte-lane merge helper.
package sram_like_responder_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned STRB_W = 4;
    localparam int unsigned SIZE_W = 3;

    typedef enum logic [SIZE_W-1:0] {
        SizeByte = 3'd0,
        SizeHalf = 3'd1,
        SizeWord = 3'd2
    } size_e;

    // Replace the byte lanes of old_word selected by strb with the lanes of new_word.
    function automatic logic [DATA_W-1:0] apply_wstrb(input logic [DATA_W-1:0] old_word,
                                                      input logic [DATA_W-1:0] new_word,
                                                      input logic [STRB_W-1:0] strb);
        logic [DATA_W-1:0] res;
        res = old_word;
        for (int b = 0; b < STRB_W; b++) begin
            if (strb[b]) res[8*b +: 8] = new_word[8*b +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/sram_like_responder_resp_fifo.sv
// Response queue: circular FIFO of QDEPTH entries, each holding response data and a countdown.
// Ports:
//   clk, resetn       clock, asynchronous active-low reset
//   push, push_data   enqueue a response (countdown starts at LATENCY-1)
//   pop               dequeue the head (only when head_ready)
//   full, empty       occupancy flags
//   count             occupancy, 0..QDEPTH
//   head_data         data of the oldest entry
//   head_ready        oldest entry present and its countdown has expired
module sram_like_responder_resp_fifo
    import sram_like_responder_pkg::*;
#(
    parameter int unsigned QDEPTH  = 4,
    parameter int unsigned LATENCY = 2,
    localparam int unsigned PW     = $clog2(QDEPTH)
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic              full,
    output logic              empty,
    output logic [PW:0]       count,
    output logic [DATA_W-1:0] head_data,
    output logic              head_ready
);

    localparam logic [3:0] LAT_CNT   = 4'(LATENCY - 1);
    localparam logic [PW:0] FULL_CNT = (PW + 1)'(QDEPTH);

    logic [DATA_W-1:0] data_q [QDEPTH];
    logic [3:0]        cnt_q  [QDEPTH];
    logic [PW-1:0]     wptr_q, rptr_q;
    logic [PW:0]       count_q, count_d;

    assign count_d = count_q + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};

    // Free slots may also count down; a push always reloads the counter, so that is harmless.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < QDEPTH; i++) cnt_q[i] <= '0;
        end else begin
            for (int i = 0; i < QDEPTH; i++) begin
                if (cnt_q[i] != 4'd0) cnt_q[i] <= cnt_q[i] - 4'd1;
            end
            if (push) begin
                cnt_q[wptr_q] <= LAT_CNT;
                wptr_q        <= wptr_q + 1'b1;
            end
            if (pop) rptr_q <= rptr_q + 1'b1;
            count_q <= count_d;
        end
    end

    // Payload needs no reset: it is only observed through a valid head.
    always_ff @(posedge clk) begin
        if (push) data_q[wptr_q] <= push_data;
    end

    assign full       = (count_q == FULL_CNT);
    assign empty      = (count_q == '0);
    assign count      = count_q;
    assign head_data  = data_q[rptr_q];
    assign head_ready = !empty && (cnt_q[rptr_q] == 4'd0);

endmodule

// File: rtl/sram_like_responder.sv
// Target-side SRAM-like bus responder backed by a local word RAM.
// Accepts one request per cycle in order and answers each with exactly one data_ok after
// LATENCY cycles; addr_ok can be gated by an LFSR to inject stalls.
// Ports:
//   clk, resetn       clock, asynchronous active-low reset
//   req, wr, wstrb    request valid, write select, byte enables
//   addr, size, wdata byte address, transfer size (unused), write data
//   addr_ok           request accepted this cycle when req=1
//   data_ok, rdata    response for the oldest outstanding request (rdata=0 for writes)
//   outstanding       current queue occupancy
module sram_like_responder
    import sram_like_responder_pkg::*;
#(
    parameter int unsigned AW        = 12,
    parameter int unsigned LATENCY   = 2,
    parameter int unsigned QDEPTH    = 4,
    parameter bit          STALL_EN  = 1'b0,
    parameter logic [7:0]  LFSR_SEED = 8'hA5
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     req,
    input  logic                     wr,
    input  logic [STRB_W-1:0]        wstrb,
    input  logic [ADDR_W-1:0]        addr,
    input  logic [SIZE_W-1:0]        size,
    input  logic [DATA_W-1:0]        wdata,
    output logic                     addr_ok,
    output logic                     data_ok,
    output logic [DATA_W-1:0]        rdata,
    output logic [$clog2(QDEPTH):0]  outstanding
);

    localparam int unsigned WORDS = 1 << AW;

    if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
        $error("sram_like_responder: LATENCY must be in 1..15");
    end
    if (QDEPTH < 2 || (QDEPTH & (QDEPTH - 1)) != 0) begin : g_bad_qdepth
        $error("sram_like_responder: QDEPTH must be a power of 2 and at least 2");
    end

    logic [DATA_W-1:0] mem [WORDS];
    logic [AW-1:0]     idx;
    logic [7:0]        lfsr_q;
    logic              full, empty, head_ready, accept;
    logic [DATA_W-1:0] head_data, push_data;

    // Upper address bits wrap, byte offset and size do not affect behaviour.
    logic unused_bits;
    assign unused_bits = ^{size, addr[ADDR_W-1:AW+2], addr[1:0], empty};

    assign idx = addr[AW+1:2];

    // Only registered state and reset feed addr_ok, never req or data_ok.
    assign addr_ok = resetn && !full && (!STALL_EN || lfsr_q[0]);
    assign accept  = req && addr_ok;

    // Combinational read sees a write committed on the previous edge.
    assign push_data = wr ? '0 : mem[idx];

    always_ff @(posedge clk) begin
        if (accept && wr) mem[idx] <= apply_wstrb(mem[idx], wdata, wstrb);
    end

    // Fibonacci LFSR, taps 8,6,5,4; the new bit enters at bit 0.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) lfsr_q <= LFSR_SEED;
        else         lfsr_q <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    end

    sram_like_responder_resp_fifo #(
        .QDEPTH  (QDEPTH),
        .LATENCY (LATENCY)
    ) u_resp_fifo (
        .clk        (clk),
        .resetn     (resetn),
        .push       (accept),
        .push_data  (push_data),
        .pop        (head_ready),
        .full       (full),
        .empty      (empty),
        .count      (outstanding),
        .head_data  (head_data),
        .head_ready (head_ready)
    );

    assign data_ok = head_ready;
    assign rdata   = head_ready ? head_data : '0;

endmodule

// File: tb/tb_sram_like_responder.sv
module tb_sram_like_responder;

    localparam int NDUT = 3;
    localparam int LAT [NDUT] = '{2, 15, 2};
    localparam bit STALL [NDUT] = '{1'b0, 1'b0, 1'b1};
    localparam int QD = 4;
    localparam logic [7:0] SEED = 8'hA5;

    typedef struct packed {
        logic        aok;
        logic        dok;
        logic [31:0] rdata;
        logic [2:0]  outs;
    } view_t;

    typedef struct packed {
        int          due;
        logic [31:0] data;
    } resp_t;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    logic        req   [NDUT];
    logic        wr    [NDUT];
    logic [3:0]  wstrb [NDUT];
    logic [31:0] addr  [NDUT];
    logic [2:0]  size  [NDUT];
    logic [31:0] wdata [NDUT];
    logic        aok   [NDUT];
    logic        dok   [NDUT];
    logic [31:0] rdata [NDUT];
    logic [2:0]  outs  [NDUT];

    sram_like_responder #(.AW(12), .LATENCY(2), .QDEPTH(QD), .STALL_EN(1'b0), .LFSR_SEED(SEED))
    dut0 (.clk(clk), .resetn(resetn), .req(req[0]), .wr(wr[0]), .wstrb(wstrb[0]), .addr(addr[0]),
          .size(size[0]), .wdata(wdata[0]), .addr_ok(aok[0]), .data_ok(dok[0]), .rdata(rdata[0]),
          .outstanding(outs[0]));

    sram_like_responder #(.AW(12), .LATENCY(15), .QDEPTH(QD), .STALL_EN(1'b0), .LFSR_SEED(SEED))
    dut1 (.clk(clk), .resetn(resetn), .req(req[1]), .wr(wr[1]), .wstrb(wstrb[1]), .addr(addr[1]),
          .size(size[1]), .wdata(wdata[1]), .addr_ok(aok[1]), .data_ok(dok[1]), .rdata(rdata[1]),
          .outstanding(outs[1]));

    sram_like_responder #(.AW(12), .LATENCY(2), .QDEPTH(QD), .STALL_EN(1'b1), .LFSR_SEED(SEED))
    dut2 (.clk(clk), .resetn(resetn), .req(req[2]), .wr(wr[2]), .wstrb(wstrb[2]), .addr(addr[2]),
          .size(size[2]), .wdata(wdata[2]), .addr_ok(aok[2]), .data_ok(dok[2]), .rdata(rdata[2]),
          .outstanding(outs[2]));

    // Reference model: word memory, queue of pending responses with due cycle, stall LFSR.
    logic [31:0] mem_m  [NDUT][4096];
    resp_t       q      [NDUT][$];
    logic [7:0]  lfsr_m [NDUT];
    int          cyc;
    view_t       obs    [NDUT];
    view_t       exp_v  [NDUT];
    bit          acc    [NDUT];
    int          checks, failures;

    task automatic model_reset();
        for (int d = 0; d < NDUT; d++) begin
            q[d].delete();
            lfsr_m[d] = SEED;
        end
    endtask

    // One clock cycle: capture expected and observed outputs, then advance the model on the edge.
    task automatic tick();
        logic [11:0] idx;
        #1;
        for (int d = 0; d < NDUT; d++) begin
            exp_v[d].aok   = resetn && (q[d].size() < QD) && (!STALL[d] || lfsr_m[d][0]);
            exp_v[d].dok   = resetn && (q[d].size() > 0) && (q[d][0].due <= cyc);
            exp_v[d].rdata = exp_v[d].dok ? q[d][0].data : 32'h0;
            exp_v[d].outs  = 3'(q[d].size());
            obs[d]         = {aok[d], dok[d], rdata[d], outs[d]};
        end
        @(posedge clk);
        cyc++;
        for (int d = 0; d < NDUT; d++) begin
            acc[d] = req[d] && exp_v[d].aok;
            if (exp_v[d].dok) void'(q[d].pop_front());
            if (acc[d]) begin
                idx = addr[d][13:2];
                if (wr[d]) begin
                    for (int b = 0; b < 4; b++)
                        if (wstrb[d][b]) mem_m[d][idx][8*b +: 8] = wdata[d][8*b +: 8];
                    q[d].push_back('{due: cyc + LAT[d] - 1, data: 32'h0});
                end else begin
                    q[d].push_back('{due: cyc + LAT[d] - 1, data: mem_m[d][idx]});
                end
            end
            lfsr_m[d] = {lfsr_m[d][6:0], ^(lfsr_m[d] & 8'hB8)};
        end
        @(negedge clk);
    endtask

    task automatic drive(input int d, input bit w, input logic [3:0] s, input logic [31:0] a,
                         input logic [31:0] dat);
        req[d] = 1'b1; wr[d] = w; wstrb[d] = s; addr[d] = a; wdata[d] = dat;
        size[d] = 3'($urandom_range(0, 2));
    endtask

    task automatic idle(input int d);
        req[d] = 1'b0; wr[d] = 1'b0; wstrb[d] = 4'h0; addr[d] = $urandom; wdata[d] = $urandom;
    endtask

    task automatic drain(input int d, output bit timed_out);
        int k;
        k = 0;
        while (q[d].size() != 0 && k < 100) begin
            tick();
            k++;
        end
        timed_out = (q[d].size() != 0);
    endtask

    // Write n words from address 0 with random data, holding each until accepted.
    task automatic fill(input int d, input int n);
        bit to;
        for (int w = 0; w < n; w++) begin
            drive(d, 1'b1, 4'hF, 32'(w * 4), $urandom);
            for (int k = 0; k < 50; k++) begin
                tick();
                if (acc[d]) break;
            end
        end
        idle(d);
        drain(d, to);
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        #1;
        for (int d = 0; d < NDUT; d++) begin
            checks++;
            if ({aok[d], dok[d], rdata[d], outs[d]} !== 38'h0) begin
                failures++;
                $display("FAIL reset_hold dut%0d got %h want 0", d, {aok[d], dok[d], rdata[d], outs[d]});
            end
        end
        @(negedge clk);
        resetn = 1'b1;
        tick();
        for (int d = 0; d < NDUT; d++) begin
            checks++;
            if (obs[d] !== exp_v[d]) begin
                failures++;
                $display("FAIL reset_release dut%0d got %h want %h", d, obs[d], exp_v[d]);
            end
        end
        checks++;
        if (obs[0].aok !== 1'b1 || obs[0].outs !== 3'd0) begin
            failures++;
            $display("FAIL reset_aok got aok=%b outs=%0d want aok=1 outs=0", obs[0].aok, obs[0].outs);
        end
    endtask

    task automatic test_write_read();
        for (int ph = 0; ph < 2; ph++) begin
            if (ph == 0) drive(0, 1'b1, 4'hF, 32'h100, 32'hDEADBEEF);
            else         drive(0, 1'b0, 4'h0, 32'h100, 32'h0);
            tick();
            idle(0);
            for (int k = 1; k <= 2; k++) begin
                tick();
                checks++;
                if (obs[0] !== exp_v[0]) begin
                    failures++;
                    $display("FAIL wr_rd_cycle ph=%0d k=%0d got %h want %h", ph, k, obs[0], exp_v[0]);
                end
            end
            checks++;
            if (obs[0].dok !== 1'b1 || obs[0].rdata !== (ph == 0 ? 32'h0 : 32'hDEADBEEF)) begin
                failures++;
                $display("FAIL wr_rd_resp ph=%0d got dok=%b rdata=%h want dok=1 rdata=%h", ph,
                         obs[0].dok, obs[0].rdata, (ph == 0 ? 32'h0 : 32'hDEADBEEF));
            end
        end
    endtask

    // Back-to-back write, partial write, read to the same word.
    task automatic test_back_to_back();
        int n;
        int t [3];
        logic [31:0] got [3];
        n = 0;
        for (int k = 0; k < 7; k++) begin
            case (k)
                0: drive(0, 1'b1, 4'hF, 32'h200, 32'h11223344);
                1: drive(0, 1'b1, 4'b0010, 32'h201, 32'h0000AB00);
                2: drive(0, 1'b0, 4'h0, 32'h202, 32'h0);
                default: idle(0);
            endcase
            tick();
            checks++;
            if (obs[0] !== exp_v[0]) begin
                failures++;
                $display("FAIL b2b_cycle k=%0d got %h want %h", k, obs[0], exp_v[0]);
            end
            if (obs[0].dok === 1'b1) begin
                if (n < 3) begin t[n] = k; got[n] = obs[0].rdata; end
                n++;
            end
        end
        checks++;
        if (n !== 3 || t[0] !== 2 || t[2] !== 4 || got[0] !== 32'h0 || got[2] !== 32'h1122AB44) begin
            failures++;
            $display("FAIL b2b_resp got n=%0d first=%0d last=%0d rdata=%h want n=3 first=2 last=4 rdata=1122ab44",
                     n, t[0], t[2], got[2]);
        end
    endtask

    task automatic test_wrap();
        logic [31:0] last;
        last = 32'h0;
        for (int k = 0; k < 6; k++) begin
            if (k == 0)      drive(0, 1'b1, 4'hF, 32'h4000, 32'h5A5A5A5A);
            else if (k == 1) drive(0, 1'b0, 4'h0, 32'h0000, 32'h0);
            else             idle(0);
            tick();
            checks++;
            if (obs[0] !== exp_v[0]) begin
                failures++;
                $display("FAIL wrap_cycle k=%0d got %h want %h", k, obs[0], exp_v[0]);
            end
            if (obs[0].dok === 1'b1) last = obs[0].rdata;
        end
        checks++;
        if (last !== 32'h5A5A5A5A) begin
            failures++;
            $display("FAIL wrap_read got %h want 5a5a5a5a", last);
        end
    endtask

    task automatic test_backpressure();
        int na, nd, t;
        int ta [5];
        int td [4];
        bit chk_full, to;
        fill(1, 4);
        na = 0; nd = 0; chk_full = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (na < 5) drive(1, 1'b0, 4'h0, 32'((na % 4) * 4), 32'h0);
            else        idle(1);
            t = cyc;
            tick();
            checks++;
            if (obs[1] !== exp_v[1]) begin
                failures++;
                $display("FAIL bp_cycle k=%0d got %h want %h", k, obs[1], exp_v[1]);
            end
            if (na == 4 && !chk_full) begin
                chk_full = 1'b1;
                checks++;
                if (obs[1].aok !== 1'b0 || obs[1].outs !== 3'd4) begin
                    failures++;
                    $display("FAIL bp_full got aok=%b outs=%0d want aok=0 outs=4", obs[1].aok, obs[1].outs);
                end
            end
            if (req[1] && obs[1].aok === 1'b1) begin
                if (na < 5) ta[na] = t;
                na++;
            end
            if (obs[1].dok === 1'b1) begin
                if (nd < 4) td[nd] = t;
                nd++;
            end
        end
        checks++;
        if (na < 5 || nd < 4) begin
            failures++;
            $display("FAIL bp_counts got accepts=%0d doks=%0d want >=5 >=4", na, nd);
        end else begin
            checks++;
            if (td[0] - ta[0] !== 15) begin
                failures++;
                $display("FAIL bp_first_latency got %0d want 15", td[0] - ta[0]);
            end
            checks++;
            if (td[1] !== td[0] + 1 || td[2] !== td[0] + 2 || td[3] !== td[0] + 3) begin
                failures++;
                $display("FAIL bp_consecutive got %0d %0d %0d %0d want consecutive", td[0], td[1], td[2], td[3]);
            end
            checks++;
            if (ta[4] !== td[0] + 1) begin
                failures++;
                $display("FAIL bp_reassert got %0d want %0d", ta[4], td[0] + 1);
            end
        end
        drain(1, to);
        checks++;
        if (to) begin failures++; $display("FAIL bp_drain got timeout want empty"); end
    endtask

    task automatic test_reset_midflight();
        int na, nd;
        logic [31:0] got;
        bit seen;
        drive(1, 1'b1, 4'hF, 32'h300, 32'hCAFEF00D);
        tick();
        idle(1);
        begin bit to; drain(1, to); end
        na = 0;
        for (int k = 0; k < 10 && na < 3; k++) begin
            drive(1, 1'b0, 4'h0, 32'h300, 32'h0);
            tick();
            if (acc[1]) na++;
        end
        idle(1);
        resetn = 1'b0;
        model_reset();
        #1;
        checks++;
        if (aok[1] !== 1'b0 || dok[1] !== 1'b0 || outs[1] !== 3'd0 || rdata[1] !== 32'h0) begin
            failures++;
            $display("FAIL midreset_hold got aok=%b dok=%b outs=%0d want 0 0 0", aok[1], dok[1], outs[1]);
        end
        @(negedge clk);
        resetn = 1'b1;
        nd = 0;
        for (int k = 0; k < 20; k++) begin
            tick();
            checks++;
            if (obs[1] !== exp_v[1]) begin
                failures++;
                $display("FAIL midreset_cycle k=%0d got %h want %h", k, obs[1], exp_v[1]);
            end
            if (obs[1].dok === 1'b1) nd++;
        end
        checks++;
        if (nd !== 0 || obs[1].outs !== 3'd0) begin
            failures++;
            $display("FAIL midreset_late got doks=%0d outs=%0d want 0 0", nd, obs[1].outs);
        end
        drive(1, 1'b0, 4'h0, 32'h300, 32'h0);
        tick();
        idle(1);
        seen = 1'b0; got = 32'h0;
        for (int k = 0; k < 25 && !seen; k++) begin
            tick();
            if (obs[1].dok === 1'b1) begin seen = 1'b1; got = obs[1].rdata; end
        end
        checks++;
        if (!seen || got !== 32'hCAFEF00D) begin
            failures++;
            $display("FAIL midreset_retain got seen=%b rdata=%h want 1 cafef00d", seen, got);
        end
    endtask

    task automatic test_stall();
        int na, nd, nstall;
        fill(2, 16);
        na = 0; nd = 0; nstall = 0;
        for (int k = 0; k < 260; k++) begin
            if (k < 200) drive(2, 1'b0, 4'h0, ($urandom & 32'hFFFF_C000) | 32'($urandom_range(0, 63)), 32'h0);
            else         idle(2);
            tick();
            checks++;
            if (obs[2] !== exp_v[2]) begin
                failures++;
                $display("FAIL stall_cycle k=%0d got %h want %h", k, obs[2], exp_v[2]);
            end
            if (req[2] && obs[2].aok === 1'b1) na++;
            if (req[2] && obs[2].aok === 1'b0) nstall++;
            if (obs[2].dok === 1'b1) nd++;
        end
        checks++;
        if (na !== nd || na == 0 || nstall == 0) begin
            failures++;
            $display("FAIL stall_count got accepts=%0d doks=%0d stalls=%0d want equal nonzero", na, nd, nstall);
        end
    endtask

    task automatic test_random();
        bit to;
        fill(0, 16);
        for (int k = 0; k < 300; k++) begin
            if ($urandom_range(0, 3) != 0)
                drive(0, ($urandom_range(0, 2) == 0), 4'($urandom),
                      ($urandom & 32'hFFFF_C000) | 32'($urandom_range(0, 63)), $urandom);
            else
                idle(0);
            tick();
            checks++;
            if (obs[0] !== exp_v[0]) begin
                failures++;
                $display("FAIL rand_cycle k=%0d got %h want %h", k, obs[0], exp_v[0]);
            end
        end
        idle(0);
        drain(0, to);
        checks++;
        if (to) begin failures++; $display("FAIL rand_drain got timeout want empty"); end
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout got running want finished");
        $fatal(1, "timeout");
    end

    initial begin
        checks = 0; failures = 0; cyc = 0;
        for (int d = 0; d < NDUT; d++) idle(d);
        model_reset();
        resetn = 1'b0;
        test_reset();
        test_write_read();
        test_back_to_back();
        test_wrap();
        test_backpressure();
        test_reset_midflight();
        test_stall();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
